// File: rtl/shift_rx_pkg.sv
// Shared definitions for the serial shift receiver: receiver states,
// default word width and the idle level of the serial line.
package shift_rx_pkg;

  localparam int DATA_W_DEF = 8;

  // The line rests high; a low sample in IDLE is a start bit.
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_HIGH = 2'd3
  } rx_state_e;

  // The counter must be able to hold DATA_W itself without wrapping.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for the shift receiver: synchronous clear, increment on
// enable, saturating at DATA_W, and a flag marking the last data bit.
module rx_bit_counter
  import shift_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(DATA_W))) begin
      count <= count + 1'b1;
    end
  end

  // Count equals the index of the data bit the next strobe will sample.
  assign last = (count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/shift_receiver.sv
// Strobe-driven serial receiver: start bit, DATA_W data bits LSB first,
// stop bit; holds the word for a valid/ack consumer, flags overrun and framing errors.
module shift_receiver
  import shift_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              bit_en,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  rx_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic              cnt_clear;
  logic              cnt_inc;
  logic              cnt_last;

  assign cnt_clear = (state == IDLE) && bit_en && (serial_in != LINE_IDLE);
  assign cnt_inc   = (state == DATA) && bit_en;

  rx_bit_counter #(
    .DATA_W (DATA_W)
  ) u_bit_counter (
    .CLK   (CLK),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .last  (cnt_last)
  );

  // Later assignments in this block take priority: a delivery in the same
  // cycle as an acknowledge keeps data_valid set and decides overrun itself.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      if (bit_en) begin
        case (state)
          IDLE: begin
            if (serial_in != LINE_IDLE) begin
              state <= DATA;
              busy  <= 1'b1;
            end
          end

          DATA: begin
            shreg <= {serial_in, shreg[DATA_W-1:1]};
            if (cnt_last) begin
              state <= STOP;
            end
          end

          STOP: begin
            if (serial_in == LINE_IDLE) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              overrun    <= data_valid && !data_ack;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end

          WAIT_HIGH: begin
            if (serial_in == LINE_IDLE) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_receiver.sv
// Self-checking bench for shift_receiver: directed frames plus randomized
// traffic, with a scoreboard queue of expected deliveries checked by a monitor.
module tb_shift_receiver;
  import shift_rx_pkg::*;

  localparam int W = 8;

  logic         CLK       = 1'b0;
  logic         reset     = 1'b0;
  logic         serial_in = 1'b1;
  logic         bit_en    = 1'b0;
  logic         data_ack  = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         overrun;
  logic         frame_err;
  logic         busy;

  shift_receiver #(.DATA_W(W)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] word;
    logic         ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   ferr_exp  = 0;
  int   ferr_seen = 0;

  // Consumer-visible model: the held word, whether it is unconsumed, overrun.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_word  = '0;
  logic         m_ovr   = 1'b0;

  int gap_lo = 4;
  int gap_hi = 4;
  bit jitter = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (jitter) serial_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // One line bit, then a gap of idle cycles so strobes are gap cycles apart.
  task automatic strobe(input logic b);
    serial_in = b;
    bit_en    = 1'b1;
    tick();
    bit_en    = 1'b0;
    idle(int'($urandom_range(gap_lo, gap_hi)) - 1);
  endtask

  task automatic send_body(input logic [W-1:0] word);
    strobe(1'b0);
    for (int i = 0; i < W; i++) strobe(word[i]);
  endtask

  // Stop-bit strobe; updates the model and the scoreboard from the frame rules.
  task automatic stop_bit(input logic [W-1:0] word, input logic ok, input logic ack);
    exp_t e;
    serial_in = ok;
    bit_en    = 1'b1;
    data_ack  = ack;
    if (ok) begin
      e.word  = word;
      e.ovr   = m_valid && !ack;
      exp_q.push_back(e);
      m_valid = 1'b1;
      m_word  = word;
      m_ovr   = e.ovr;
    end else begin
      ferr_exp++;
      if (ack && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    tick();
    bit_en   = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] word);
    send_body(word);
    stop_bit(word, 1'b1, 1'b0);
    serial_in = 1'b1;
    idle(2);
  endtask

  task automatic ack();
    data_ack = 1'b1;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    tick();
    data_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h0);
    check({tag, "_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Monitor: a delivery shows as valid rising, the word changing, or overrun rising.
  logic         prev_v = 1'b0;
  logic         prev_o = 1'b0;
  logic [W-1:0] prev_d = '0;

  always @(negedge CLK) begin
    exp_t e;
    if (reset && data_valid &&
        (!prev_v || (data_out != prev_d) || (overrun && !prev_o))) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_delivery: got word 0x%0h with no frame pending", data_out);
      end else begin
        e = exp_q.pop_front();
        check("mon_word", 32'(data_out), 32'(e.word));
        check("mon_overrun", 32'(overrun), 32'(e.ovr));
      end
    end
    if (frame_err === 1'b1) ferr_seen++;
    prev_v = data_valid;
    prev_o = overrun;
    prev_d = data_out;
  end

  initial begin
    logic [W-1:0] w;
    logic         ok;
    logic         ak;

    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // 0xA5 with one strobe every 4 cycles
    send_body(8'hA5);
    check("a5_valid_before_stop", 32'(data_valid), 32'h0);
    stop_bit(8'hA5, 1'b1, 1'b0);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_valid", 32'(data_valid), 32'h1);
    check("a5_busy", 32'(busy), 32'h0);
    serial_in = 1'b1;
    idle(2);
    ack();
    check("a5_acked_valid", 32'(data_valid), 32'h0);

    // 0x3C with a bad stop bit, line held low, then 0x81
    send_body(8'h3C);
    stop_bit(8'h3C, 1'b0, 1'b0);
    check("ferr_pulse", 32'(frame_err), 32'h1);
    check("ferr_valid", 32'(data_valid), 32'h0);
    check("ferr_busy", 32'(busy), 32'h1);
    tick();
    check("ferr_one_cycle", 32'(frame_err), 32'h0);
    strobe(1'b0);
    strobe(1'b0);
    check("wait_high_busy", 32'(busy), 32'h1);
    strobe(1'b1);
    check("wait_high_released", 32'(busy), 32'h0);
    send_frame(8'h81);
    check("after_ferr_data", 32'(data_out), 32'h81);
    ack();

    // Two unacknowledged frames
    send_frame(8'h11);
    send_frame(8'h22);
    check("ovr_data", 32'(data_out), 32'h22);
    check("ovr_valid", 32'(data_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    ack();
    check("ovr_ack_valid", 32'(data_valid), 32'h0);
    check("ovr_ack_flag", 32'(overrun), 32'h0);

    // Acknowledge coinciding with a delivery
    send_frame(8'h11);
    send_body(8'h55);
    stop_bit(8'h55, 1'b1, 1'b1);
    check("ack_at_stop_data", 32'(data_out), 32'h55);
    check("ack_at_stop_valid", 32'(data_valid), 32'h1);
    check("ack_at_stop_ovr", 32'(overrun), 32'h0);
    serial_in = 1'b1;
    idle(2);
    ack();

    // Reset after four data bits, then a clean 0xF0
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    reset   = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_word  = '0;
    tick();
    check_all_zero("midframe_reset");
    reset     = 1'b1;
    serial_in = 1'b1;
    tick();
    send_frame(8'hF0);
    check("post_reset_data", 32'(data_out), 32'hF0);
    ack();

    // Irregular strobe spacing with the line toggling between strobes
    gap_lo = 1;
    gap_hi = 7;
    jitter = 1'b1;
    send_frame(8'h96);
    check("jitter_data", 32'(data_out), 32'h96);
    ack();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      jitter = 1'($urandom_range(0, 1));
      do w = W'($urandom); while (m_valid && (w == m_word));
      ok = ($urandom_range(0, 7) != 0);
      ak = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) strobe(1'b1);
      send_body(w);
      stop_bit(w, ok, ak);
      if (!ok) strobe(1'b1);
      serial_in = 1'b1;
      idle(int'($urandom_range(1, 4)));
      if ($urandom_range(0, 1) == 1) ack();
    end

    serial_in = 1'b1;
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
    check("final_valid", 32'(data_valid), 32'(m_valid));
    check("final_overrun", 32'(overrun), 32'(m_ovr));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
